// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: receiver byte inputs and payload stream of uart_frame_parser.
// The parser connects through the slave modport; the byte source/consumer uses master.
interface uart_frame_parser_if #(parameter int DATA_WIDTH = 8);
   logic                  rx_done;
   logic                  rx_error;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  frame_ok;
   logic                  frame_err;
   logic [1:0]            err_code;
   logic                  drop;
   modport master (
      output rx_done, rx_error, rx_data, out_ready,
      input  out_valid, out_data, out_last, frame_ok, frame_err, err_code, drop
   );
   modport slave (
      input  rx_done, rx_error, rx_data, out_ready,
      output out_valid, out_data, out_last, frame_ok, frame_err, err_code, drop
   );
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles HEADER,LEN,PAYLOAD,CHK frames and replays the payload.
// Define PARSER_TIMEOUT_EN to build the inter-byte timeout (adds TIMEOUT_CYCLES, code 3).
module uart_frame_parser #(
   parameter int                DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] HEADER = 8'hA5,
`ifdef PARSER_TIMEOUT_EN
   parameter int                TIMEOUT_CYCLES = 100000,
`endif
   parameter int                MAX_LEN = 16
) (
   input logic                clk,
   input logic                rst,
   uart_frame_parser_if.slave bus
);
   localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_L = 8'(MAX_LEN);
   localparam logic [2:0] S_HUNT = 3'd0;
   localparam logic [2:0] S_LEN  = 3'd1;
   localparam logic [2:0] S_PAY  = 3'd2;
   localparam logic [2:0] S_CHK  = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic                  rx_done_q;
   logic [7:0]            len_q, len_d, idx_q, idx_d, rd_q, rd_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d, sum_nx;
   logic                  frame_ok_q, frame_ok_d, frame_err_q, frame_err_d, drop_q, drop_d;
   logic [1:0]            err_code_q, err_code_d, abort_code;
   logic                  byte_stb, wr_en, xfer, last, abort, tmo_hit;
   logic [DATA_WIDTH-1:0] mem [0:(1<<AW)-1];

   assign byte_stb = bus.rx_done & ~rx_done_q;
   assign sum_nx   = sum_q + bus.rx_data;
   assign xfer     = state_q == S_OUT && bus.out_ready;
   assign last     = rd_q == len_q - 8'd1;

   assign bus.out_valid = state_q == S_OUT;
   assign bus.out_data  = bus.out_valid ? mem[rd_q[AW-1:0]] : '0;
   assign bus.out_last  = bus.out_valid && last;
   assign bus.frame_ok  = frame_ok_q;
   assign bus.frame_err = frame_err_q;
   assign bus.err_code  = err_code_q;
   assign bus.drop      = drop_q;

`ifdef PARSER_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] tmo_q;
   logic        tmo_act;
   assign tmo_act = state_q == S_LEN || state_q == S_PAY || state_q == S_CHK;
   assign tmo_hit = tmo_act && !byte_stb && tmo_q == TMO_LAST;
   always_ff @(posedge clk) begin
      tmo_q <= (rst || byte_stb || !tmo_act) ? '0 : tmo_q + 32'd1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      rd_d        = rd_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      drop_d      = 1'b0;
      wr_en       = 1'b0;
      abort       = 1'b0;
      abort_code  = 2'd0;
      case (state_q)
         S_HUNT: state_d = (byte_stb && bus.rx_data == HEADER && !bus.rx_error) ? S_LEN : S_HUNT;
         S_LEN: if (byte_stb) begin
            if (bus.rx_error) {abort, abort_code} = {1'b1, 2'd1};
            else if (bus.rx_data > MAX_L) {abort, abort_code} = {1'b1, 2'd2};
            else begin
               len_d   = bus.rx_data;
               sum_d   = bus.rx_data;
               idx_d   = 8'd0;
               state_d = bus.rx_data == '0 ? S_CHK : S_PAY;
            end
         end
         S_PAY: if (byte_stb) begin
            if (bus.rx_error) {abort, abort_code} = {1'b1, 2'd1};
            else begin
               wr_en   = 1'b1;
               sum_d   = sum_nx;
               idx_d   = idx_q + 8'd1;
               state_d = idx_q == len_q - 8'd1 ? S_CHK : S_PAY;
            end
         end
         // parity is checked first so it wins over a bad checksum
         S_CHK: if (byte_stb) begin
            if (bus.rx_error) {abort, abort_code} = {1'b1, 2'd1};
            else if (sum_nx != '0) {abort, abort_code} = {1'b1, 2'd0};
            else begin
               frame_ok_d = 1'b1;
               rd_d       = 8'd0;
               state_d    = len_q == 8'd0 ? S_HUNT : S_OUT;
            end
         end
         S_OUT: begin
            drop_d  = byte_stb;
            rd_d    = xfer ? rd_q + 8'd1 : rd_q;
            state_d = (xfer && last) ? S_HUNT : S_OUT;
         end
         default: state_d = S_HUNT;
      endcase
      if (tmo_hit) {abort, abort_code} = {1'b1, 2'd3};
      if (abort) begin
         state_d     = S_HUNT;
         idx_d       = 8'd0;
         sum_d       = '0;
         frame_err_d = 1'b1;
         err_code_d  = abort_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HUNT;
         rx_done_q   <= 1'b1;
         len_q       <= 8'd0;
         idx_q       <= 8'd0;
         rd_q        <= 8'd0;
         sum_q       <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_done_q   <= bus.rx_done;
         len_q       <= len_d;
         idx_q       <= idx_d;
         rd_q        <= rd_d;
         sum_q       <= sum_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         drop_q      <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[idx_q[AW-1:0]] <= bus.rx_data;
   end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Downstream consumer of the UART receiver. Takes its byte-level outputs (rx_done level, rx_data, rx_error) and assembles framed packets of the form HEADER, LEN, PAYLOAD[LEN], CHK. The payload is buffered internally and replayed to the application over a valid/ready byte stream. A per-frame status pulse reports success or the failure cause.

Parameters:
DATA_WIDTH, 8, width of rx_data and out_data; fixed at 8 for this block.
HEADER, 8'hA5, start-of-frame byte.
MAX_LEN, 16, maximum payload length in bytes (1..255); sets the buffer depth.
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_done  input  1  receiver done level; 0 while a byte is in flight, 1 when it completes or the receiver is idle
rx_error  input  1  parity error flag for the byte just completed
rx_data  input  8  byte received
out_valid  output  1  payload byte available
out_ready  input  1  consumer accepts the byte
out_data  output  8  payload byte
out_last  output  1  marks the final payload byte of the frame
frame_ok  output  1  one-cycle pulse: a good frame was committed
frame_err  output  1  one-cycle pulse: the frame was discarded
err_code  output  2  cause of the discard: 0 checksum, 1 parity, 2 length, 3 timeout; holds until the next frame_err
drop  output  1  one-cycle pulse: a byte arrived while the parser was busy replaying and was discarded

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high (rst). All state changes on posedge clk.
- Byte strobe: byte_stb = rx_done & ~rx_done_d.
  - rx_done_d resets to 1, so no false strobe is generated after reset.
  - On byte_stb, rx_data and rx_error are sampled in that same cycle.
- Reset values: out_valid=0, out_last=0, out_data=0, frame_ok=0, frame_err=0, err_code=0, drop=0. The FSM resets to S_HUNT and all counters to 0.
- FSM states and transitions:
  - S_HUNT: on byte_stb with data==HEADER and rx_error=0, go to S_LEN. Any other byte is ignored silently.
  - S_LEN: on byte_stb:
    - rx_error=1 -> abort with code 1.
    - LEN>MAX_LEN -> abort with code 2.
    - LEN==0 -> S_CHK.
    - otherwise S_PAY.
    - In all non-abort cases, sum<=LEN and len_reg<=LEN.
  - S_PAY: each byte_stb writes buf[idx], sum<=sum+byte (mod 256), idx++. After the LEN-th byte, go to S_CHK. rx_error on any byte -> abort with code 1.
  - S_CHK: on byte_stb:
    - If (sum+byte) mod 256 == 0 and rx_error=0: pulse frame_ok and go to S_OUT. For LEN==0, go to S_HUNT instead.
    - Else abort with code 1 (parity) or code 0 (checksum).
  - S_OUT: replay buf[0..len_reg-1].
    - out_valid=1 with out_data=buf[rd].
    - A transfer occurs when out_valid & out_ready; rd then advances.
    - out_last=1 when rd==len_reg-1.
    - After the last transfer: out_valid=0 the next cycle, go to S_HUNT.
    - out_data and out_valid hold stable while out_ready=0.
    - byte_stb in S_OUT -> drop pulse; the byte is discarded.
- Abort: pulse frame_err for one cycle, set err_code, go to S_HUNT, clear idx and sum. Nothing is emitted on the output stream.
- Latencies:
  - frame_ok is asserted the cycle after the CHK byte_stb.
  - The first out_valid is asserted in the same cycle as frame_ok.
  - Throughput is one byte per cycle while out_ready=1.
- Simultaneous events:
  - rx_error together with a bad checksum reports code 1 (parity has priority).
  - rst overrides everything, including an in-progress replay; the buffer contents are left undefined.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined: a counter is cleared on every byte_stb and increments in S_LEN, S_PAY and S_CHK. On reaching TIMEOUT_CYCLES-1 the frame aborts with code 3. The counter is inactive in S_HUNT and S_OUT.
- Undefined: no counter is built. Code 3 is never produced and a partial frame waits indefinitely.

Test Plan:
- Good frame: A5 03 11 22 33 97, out_ready=1 -> frame_ok=1, out_data 11,22,33 on consecutive cycles, out_last on 33, frame_err=0.
- Bad checksum: A5 03 11 22 33 98 -> frame_err=1, err_code=0, out_valid never asserted; the next good frame parses normally.
- Parity abort and oversize length:
  - rx_error=1 on payload byte 2 -> frame_err, err_code=1.
  - A5 11 with MAX_LEN=16 -> frame_err, err_code=2.
- Backpressure and drop:
  - Good frame with out_ready toggled 1,0,0,1 -> each byte is held until accepted, no duplicates or losses.
  - A byte arriving during replay -> drop=1.
- Zero-length and hunting:
  - Stream 00 FF A5 00 00 -> the leading bytes are ignored, then frame_ok=1 with no out_valid.
  - rst asserted during S_PAY -> all outputs return to reset values the next cycle.
- Timeout (PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=50): A5 02 11 followed by 50 idle cycles -> frame_err, err_code=3.
